affine_point_transformer: RTL and testbench

- Sequential fixed-point engine that applies a full affine model/camera transform to one 3D point: out = R·(S∘p) + T.
- Successor to the fixed Q16.16 dot-product helpers. Word width and fractional bits are parametrised; rounding and saturation are selectable.
- Adds a per-point mode (full / no-scale / rotate-only / passthrough), an overflow flag and valid/ready handshakes.
- Sits in the renderer transformer stage: model→world and world→camera vertex transforms, three points per triangle issued back-to-back.

---
 rtl/fx_transform_pkg.sv | 58 +++++
 rtl/affine_point_transformer_if.sv | 25 ++
 rtl/fx_dot3.sv | 35 +++
 rtl/affine_point_transformer.sv | 147 ++++++++++++++
 tb/tb_affine_point_transformer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_transform_pkg.sv
// Shared fixed-point types and helpers for the affine point transformer.
// The helpers work on one wide signed word so that any DATA_W up to 64 fits.
package fx_transform_pkg;

  localparam int MAX_W = 130;

  typedef enum logic [1:0] {
    MODE_SRT  = 2'b00,
    MODE_RT   = 2'b01,
    MODE_R    = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_ROW   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Bundle layouts for DATA_W=32, first element in the most significant bits.
  typedef logic signed [31:0] fx32_t;
  typedef struct packed { fx32_t x, y, z; } point3d_t;
  typedef struct packed {
    fx32_t r11, r12, r13, r21, r22, r23, r31, r32, r33;
  } matrix_t;
  typedef struct packed {
    matrix_t  rot;
    point3d_t scale;
    point3d_t trans;
  } affine_t;

  function automatic logic signed [MAX_W-1:0] fx_round_shift(
    input logic signed [MAX_W-1:0] v, input int frac, input bit rnd);
    logic signed [MAX_W-1:0] bias;
    bias = '0;
    if (rnd && frac > 0) bias = MAX_W'(1) << (frac - 1);
    return (v + bias) >>> frac;
  endfunction

  function automatic logic fx_ovf(input logic signed [MAX_W-1:0] v, input int dw);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (MAX_W'(1) << (dw - 1)) - MAX_W'(1);
    lo = -(MAX_W'(1) << (dw - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [MAX_W-1:0] fx_saturate(
    input logic signed [MAX_W-1:0] v, input int dw, input bit sat);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (MAX_W'(1) << (dw - 1)) - MAX_W'(1);
    lo = -(MAX_W'(1) << (dw - 1));
    if (sat && v > hi) return hi;
    if (sat && v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/affine_point_transformer_if.sv
// Operand/result handshake bundle. A transfer happens on a clock edge where
// valid && ready; the source holds its payload stable until then.
interface affine_point_transformer_if #(parameter int DATA_W = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [3*DATA_W-1:0]   in_point;
  logic [9*DATA_W-1:0]   in_rot;
  logic [3*DATA_W-1:0]   in_scale;
  logic [3*DATA_W-1:0]   in_trans;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*DATA_W-1:0]   out_point;
  logic                  out_ovf;

  modport master (
    output in_valid, in_mode, in_point, in_rot, in_scale, in_trans, out_ready,
    input  in_ready, out_valid, out_point, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_point, in_rot, in_scale, in_trans, out_ready,
    output in_ready, out_valid, out_point, out_ovf
  );
endinterface

// File: rtl/fx_dot3.sv
// Combinational three-term fixed-point dot product plus addend, followed by
// round/shift and saturate-or-wrap to DATA_W with an overflow flag.
module fx_dot3
  import fx_transform_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ROUND     = 1,
  parameter int SATURATE  = 1
) (
  input  logic signed [DATA_W-1:0]   i_a0,
  input  logic signed [DATA_W-1:0]   i_a1,
  input  logic signed [DATA_W-1:0]   i_a2,
  input  logic signed [DATA_W-1:0]   i_b0,
  input  logic signed [DATA_W-1:0]   i_b1,
  input  logic signed [DATA_W-1:0]   i_b2,
  input  logic signed [2*DATA_W+1:0] i_addend,
  output logic signed [DATA_W-1:0]   o_res,
  output logic                       o_ovf
);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = 2 * DATA_W + 2;

  logic signed [PW-1:0]    w_p0, w_p1, w_p2;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [MAX_W-1:0] w_shift;

  assign w_p0    = PW'(i_a0) * PW'(i_b0);
  assign w_p1    = PW'(i_a1) * PW'(i_b1);
  assign w_p2    = PW'(i_a2) * PW'(i_b2);
  assign w_acc   = ACC_W'(w_p0) + ACC_W'(w_p1) + ACC_W'(w_p2) + i_addend;
  assign w_shift = fx_round_shift(MAX_W'(w_acc), FRAC_BITS, ROUND != 0);
  assign o_ovf   = fx_ovf(w_shift, DATA_W);
  assign o_res   = DATA_W'(fx_saturate(w_shift, DATA_W, SATURATE != 0));
endmodule

// File: rtl/affine_point_transformer.sv
// Sequential affine transform out = R*(S.*p) + T: one SCALE cycle (optional)
// then one ROW cycle per output coordinate, result held until consumed.
module affine_point_transformer
  import fx_transform_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ROUND     = 1,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  affine_point_transformer_if.slave   io_bus,
  output logic [1:0]                  o_dbg_state
);
  localparam int ACC_W = 2 * DATA_W + 2;
  localparam int W3    = 3 * DATA_W;

  state_e              r_state;
  logic [1:0]          r_row;
  mode_e               r_mode;
  logic [W3-1:0]       r_p, r_scale, r_trans, r_out;
  logic [9*DATA_W-1:0] r_rot;
  logic                r_ovf, r_valid;

  logic                     w_accept;
  logic [W3-1:0]            w_rot_row;
  logic signed [DATA_W-1:0] w_t;
  logic signed [DATA_W-1:0] w_a [3][3];
  logic signed [DATA_W-1:0] w_b [3][3];
  logic signed [ACC_W-1:0]  w_add [3];
  logic signed [DATA_W-1:0] w_res [3];
  logic                     w_ovf [3];

  assign io_bus.in_ready  = (r_state == ST_IDLE) || (r_state == ST_OUT && io_bus.out_ready);
  assign w_accept         = io_bus.in_valid && io_bus.in_ready;
  assign io_bus.out_valid = r_valid;
  assign io_bus.out_point = r_out;
  assign io_bus.out_ovf   = r_ovf;
  assign o_dbg_state      = r_state;

  always_comb begin
    case (r_row)
      2'd0:    begin w_rot_row = r_rot[9*DATA_W-1 -: W3]; w_t = r_trans[W3-1 -: DATA_W];       end
      2'd1:    begin w_rot_row = r_rot[6*DATA_W-1 -: W3]; w_t = r_trans[2*DATA_W-1 -: DATA_W]; end
      default: begin w_rot_row = r_rot[W3-1:0];           w_t = r_trans[DATA_W-1:0];          end
    endcase
  end

  // SCALE uses lane 0 of every unit (one product each); ROW uses unit 0 only.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 3; j++) begin
        w_a[g][j] = '0;
        w_b[g][j] = '0;
      end
      w_add[g] = '0;
    end
    if (r_state == ST_SCALE) begin
      for (int g = 0; g < 3; g++) begin
        w_a[g][0] = r_scale[(2-g)*DATA_W +: DATA_W];
        w_b[g][0] = r_p[(2-g)*DATA_W +: DATA_W];
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        w_a[0][j] = w_rot_row[(2-j)*DATA_W +: DATA_W];
        w_b[0][j] = r_p[(2-j)*DATA_W +: DATA_W];
      end
      if (r_mode == MODE_SRT || r_mode == MODE_RT) w_add[0] = ACC_W'(w_t) <<< FRAC_BITS;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dot
    fx_dot3 #(
      .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ROUND(ROUND), .SATURATE(SATURATE)
    ) u_dot (
      .i_a0(w_a[g][0]), .i_a1(w_a[g][1]), .i_a2(w_a[g][2]),
      .i_b0(w_b[g][0]), .i_b1(w_b[g][1]), .i_b2(w_b[g][2]),
      .i_addend(w_add[g]), .o_res(w_res[g]), .o_ovf(w_ovf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_mode  <= MODE_SRT;
      r_p     <= '0;
      r_scale <= '0;
      r_trans <= '0;
      r_rot   <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_SCALE: begin
          r_p     <= {w_res[0], w_res[1], w_res[2]};
          r_ovf   <= r_ovf | w_ovf[0] | w_ovf[1] | w_ovf[2];
          r_row   <= 2'd0;
          r_state <= ST_ROW;
        end
        ST_ROW: begin
          case (r_row)
            2'd0:    r_out[W3-1 -: DATA_W]       <= w_res[0];
            2'd1:    r_out[2*DATA_W-1 -: DATA_W] <= w_res[0];
            default: r_out[DATA_W-1:0]           <= w_res[0];
          endcase
          r_ovf <= r_ovf | w_ovf[0];
          if (r_row == 2'd2) begin
            r_state <= ST_OUT;
            r_valid <= 1'b1;
          end else begin
            r_row <= r_row + 2'd1;
          end
        end
        ST_OUT: begin
          if (io_bus.out_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      // Accept overrides the OUT->IDLE step so a new point can start on the same edge.
      if (w_accept) begin
        r_mode  <= mode_e'(io_bus.in_mode);
        r_p     <= io_bus.in_point;
        r_rot   <= io_bus.in_rot;
        r_scale <= io_bus.in_scale;
        r_trans <= io_bus.in_trans;
        r_ovf   <= 1'b0;
        r_row   <= 2'd0;
        r_valid <= 1'b0;
        case (mode_e'(io_bus.in_mode))
          MODE_SRT:  r_state <= ST_SCALE;
          MODE_PASS: begin
            r_state <= ST_OUT;
            r_out   <= io_bus.in_point;
            r_valid <= 1'b1;
          end
          default:   r_state <= ST_ROW;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_affine_point_transformer.sv
// Directed bench: DUT A (round, saturate) and DUT B (truncate, wrap) see the
// same stimulus; each scenario task checks its own hand-computed results.
module tb_affine_point_transformer;
  import fx_transform_pkg::*;

  localparam int W = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] dbg_a, dbg_b;

  always #5 clk = ~clk;

  affine_point_transformer_if #(.DATA_W(W)) bus_a ();
  affine_point_transformer_if #(.DATA_W(W)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_mode   = bus_a.in_mode;
  assign bus_b.in_point  = bus_a.in_point;
  assign bus_b.in_rot    = bus_a.in_rot;
  assign bus_b.in_scale  = bus_a.in_scale;
  assign bus_b.in_trans  = bus_a.in_trans;
  assign bus_b.out_ready = bus_a.out_ready;

  affine_point_transformer #(.DATA_W(W), .FRAC_BITS(16), .ROUND(1), .SATURATE(1)) u_dut_a (
    .clk(clk), .rst(rst), .io_bus(bus_a), .o_dbg_state(dbg_a)
  );
  affine_point_transformer #(.DATA_W(W), .FRAC_BITS(16), .ROUND(0), .SATURATE(0)) u_dut_b (
    .clk(clk), .rst(rst), .io_bus(bus_b), .o_dbg_state(dbg_b)
  );

  function automatic logic [95:0] pt(input logic [31:0] x, y, z);
    return {x, y, z};
  endfunction

  function automatic logic [287:0] mat(input logic [31:0] a, b, c, d, e, f, g, h, i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  logic [287:0] id_m, rz_m;

  // Present a bundle, wait (bounded) for in_ready, return #1 after the accept edge.
  task automatic send(input logic [1:0] mode, input logic [95:0] p, input logic [287:0] r,
                      input logic [95:0] s, input logic [95:0] t);
    int n;
    n = 0;
    bus_a.in_mode  = mode;
    bus_a.in_point = p;
    bus_a.in_rot   = r;
    bus_a.in_scale = s;
    bus_a.in_trans = t;
    bus_a.in_valid = 1'b1;
    while (bus_a.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (bus_a.in_ready !== 1'b1) begin
      bad++; $display("FAIL accept_timeout in_ready=%b required=1", bus_a.in_ready);
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus_a.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus_a.out_valid, bus_a.out_ovf, bus_a.in_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_flags got v/ovf/rdy=%b required=001",
                      {bus_a.out_valid, bus_a.out_ovf, bus_a.in_ready});
    end
    total++;
    if (bus_a.out_point !== 96'd0) begin
      bad++; $display("FAIL reset_point got=%h required=0", bus_a.out_point);
    end
    total++;
    if (dbg_a !== ST_IDLE) begin
      bad++; $display("FAIL reset_state got=%0d required=%0d", dbg_a, ST_IDLE);
    end
  endtask

  task automatic test_mode_srt();
    int lat;
    send(2'b00, pt(ONE, 2*ONE, 3*ONE), id_m, pt(2*ONE, 2*ONE, 2*ONE), pt(ONE, 0, 0));
    wait_valid(lat);
    total++;
    if (lat != 4) begin bad++; $display("FAIL srt_latency got=%0d required=4", lat); end
    total++;
    if ({bus_a.out_point, bus_a.out_ovf} !== {pt(3*ONE, 4*ONE, 6*ONE), 1'b0}) begin
      bad++; $display("FAIL srt_result_a got=%h/%b required=%h/0", bus_a.out_point,
                      bus_a.out_ovf, pt(3*ONE, 4*ONE, 6*ONE));
    end
    total++;
    if ({bus_b.out_point, bus_b.out_ovf} !== {pt(3*ONE, 4*ONE, 6*ONE), 1'b0}) begin
      bad++; $display("FAIL srt_result_b got=%h/%b required=%h/0", bus_b.out_point,
                      bus_b.out_ovf, pt(3*ONE, 4*ONE, 6*ONE));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_modes_r_rt_pass();
    int lat;
    // Scale and translation are non-trivial so a wrongly applied stage shows up.
    send(2'b10, pt(ONE, 2*ONE, 3*ONE), rz_m, pt(3*ONE, 3*ONE, 3*ONE), pt(5*ONE, 5*ONE, 5*ONE));
    wait_valid(lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL r_latency got=%0d required=3", lat); end
    total++;
    if ({bus_a.out_point, bus_a.out_ovf} !== {pt(32'hFFFE0000, ONE, 3*ONE), 1'b0}) begin
      bad++; $display("FAIL r_result got=%h/%b required=%h/0", bus_a.out_point,
                      bus_a.out_ovf, pt(32'hFFFE0000, ONE, 3*ONE));
    end
    @(posedge clk); #1;

    send(2'b01, pt(ONE, 2*ONE, 3*ONE), rz_m, pt(3*ONE, 3*ONE, 3*ONE), pt(5*ONE, 5*ONE, 5*ONE));
    wait_valid(lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL rt_latency got=%0d required=3", lat); end
    total++;
    if ({bus_a.out_point, bus_a.out_ovf} !== {pt(3*ONE, 6*ONE, 8*ONE), 1'b0}) begin
      bad++; $display("FAIL rt_result got=%h/%b required=%h/0", bus_a.out_point,
                      bus_a.out_ovf, pt(3*ONE, 6*ONE, 8*ONE));
    end
    @(posedge clk); #1;

    // Passthrough result is already valid in the first cycle after the accept edge.
    send(2'b11, pt(ONE, 2*ONE, 3*ONE), rz_m, pt(3*ONE, 3*ONE, 3*ONE), pt(5*ONE, 5*ONE, 5*ONE));
    wait_valid(lat);
    total++;
    if (lat != 0) begin bad++; $display("FAIL pass_latency got=%0d required=0", lat); end
    total++;
    if ({bus_a.out_point, bus_a.out_ovf} !== {pt(ONE, 2*ONE, 3*ONE), 1'b0}) begin
      bad++; $display("FAIL pass_result got=%h/%b required=%h/0", bus_a.out_point,
                      bus_a.out_ovf, pt(ONE, 2*ONE, 3*ONE));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int lat;
    send(2'b00, pt(32'h7FFF0000, 0, 0), id_m, pt(2*ONE, ONE, ONE), pt(0, 0, 0));
    wait_valid(lat);
    total++;
    if ({bus_a.out_point, bus_a.out_ovf} !== {pt(32'h7FFFFFFF, 0, 0), 1'b1}) begin
      bad++; $display("FAIL sat_clamp got=%h/%b required=%h/1", bus_a.out_point,
                      bus_a.out_ovf, pt(32'h7FFFFFFF, 0, 0));
    end
    total++;
    if ({bus_b.out_point, bus_b.out_ovf} !== {pt(32'hFFFE0000, 0, 0), 1'b1}) begin
      bad++; $display("FAIL sat_wrap got=%h/%b required=%h/1", bus_b.out_point,
                      bus_b.out_ovf, pt(32'hFFFE0000, 0, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    int lat;
    logic [287:0] half_m;
    half_m = mat(32'h00008000, 0, 0, 0, ONE, 0, 0, 0, ONE);
    send(2'b10, pt(32'h00000001, 2*ONE, 3*ONE), half_m, pt(ONE, ONE, ONE), pt(7*ONE, 0, 0));
    wait_valid(lat);
    total++;
    if ({bus_a.out_point, bus_a.out_ovf} !== {pt(32'h00000001, 2*ONE, 3*ONE), 1'b0}) begin
      bad++; $display("FAIL round_pos_a got=%h/%b required=%h/0", bus_a.out_point,
                      bus_a.out_ovf, pt(32'h00000001, 2*ONE, 3*ONE));
    end
    total++;
    if (bus_b.out_point !== pt(32'h00000000, 2*ONE, 3*ONE)) begin
      bad++; $display("FAIL trunc_pos_b got=%h required=%h", bus_b.out_point,
                      pt(32'h00000000, 2*ONE, 3*ONE));
    end
    @(posedge clk); #1;

    send(2'b10, pt(32'hFFFFFFFF, 2*ONE, 3*ONE), half_m, pt(ONE, ONE, ONE), pt(7*ONE, 0, 0));
    wait_valid(lat);
    total++;
    if (bus_a.out_point !== pt(32'h00000000, 2*ONE, 3*ONE)) begin
      bad++; $display("FAIL round_neg_a got=%h required=%h", bus_a.out_point,
                      pt(32'h00000000, 2*ONE, 3*ONE));
    end
    total++;
    if (bus_b.out_point !== pt(32'hFFFFFFFF, 2*ONE, 3*ONE)) begin
      bad++; $display("FAIL trunc_neg_b got=%h required=%h", bus_b.out_point,
                      pt(32'hFFFFFFFF, 2*ONE, 3*ONE));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus_a.out_ready = 1'b0;
    send(2'b10, pt(ONE, 2*ONE, 3*ONE), id_m, pt(0, 0, 0), pt(0, 0, 0));
    wait_valid(lat);
    bus_a.in_mode  = 2'b01;
    bus_a.in_point = pt(4*ONE, 5*ONE, 6*ONE);
    bus_a.in_rot   = id_m;
    bus_a.in_trans = pt(ONE, ONE, ONE);
    bus_a.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_point} !== {2'b10, pt(ONE, 2*ONE, 3*ONE)}) begin
        bad++; $display("FAIL stall_%0d got v/rdy=%b%b pt=%h required=10 %h", k, bus_a.out_valid,
                        bus_a.in_ready, bus_a.out_point, pt(ONE, 2*ONE, 3*ONE));
      end
      @(posedge clk); #1;
    end
    bus_a.out_ready = 1'b1;
    #1;
    total++;
    if (bus_a.in_ready !== 1'b1) begin
      bad++; $display("FAIL release_ready got=%b required=1", bus_a.in_ready);
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    total++;
    if (bus_a.out_valid !== 1'b0) begin
      bad++; $display("FAIL release_consumed got=%b required=0", bus_a.out_valid);
    end
    wait_valid(lat);
    total++;
    if (lat != 3 || bus_a.out_point !== pt(5*ONE, 6*ONE, 7*ONE)) begin
      bad++; $display("FAIL bp_second got lat=%0d pt=%h required lat=3 pt=%h", lat,
                      bus_a.out_point, pt(5*ONE, 6*ONE, 7*ONE));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    send(2'b11, pt(ONE, ONE, ONE), id_m, pt(0, 0, 0), pt(0, 0, 0));
    bus_a.in_point = pt(2*ONE, 2*ONE, 2*ONE);
    bus_a.in_valid = 1'b1;
    total++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_point} !== {2'b11, pt(ONE, ONE, ONE)}) begin
      bad++; $display("FAIL b2b_first got v/rdy=%b%b pt=%h required=11 %h", bus_a.out_valid,
                      bus_a.in_ready, bus_a.out_point, pt(ONE, ONE, ONE));
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    total++;
    if ({bus_a.out_valid, bus_a.out_point} !== {1'b1, pt(2*ONE, 2*ONE, 2*ONE)}) begin
      bad++; $display("FAIL b2b_second got v=%b pt=%h required=1 %h", bus_a.out_valid,
                      bus_a.out_point, pt(2*ONE, 2*ONE, 2*ONE));
    end
    @(posedge clk); #1;
    total++;
    if (bus_a.out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got=%b required=0", bus_a.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    send(2'b10, pt(9*ONE, 9*ONE, 9*ONE), id_m, pt(0, 0, 0), pt(0, 0, 0));
    @(posedge clk); #1;
    total++;
    if (dbg_a !== ST_ROW) begin
      bad++; $display("FAIL pre_reset_state got=%0d required=%0d", dbg_a, ST_ROW);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_point} !== {2'b01, 96'd0}) begin
      bad++; $display("FAIL mid_reset got v/rdy=%b%b pt=%h required=01 0", bus_a.out_valid,
                      bus_a.in_ready, bus_a.out_point);
    end
    send(2'b10, pt(ONE, 2*ONE, 3*ONE), id_m, pt(0, 0, 0), pt(0, 0, 0));
    wait_valid(lat);
    total++;
    if (lat != 3 || {bus_a.out_point, bus_a.out_ovf} !== {pt(ONE, 2*ONE, 3*ONE), 1'b0}) begin
      bad++; $display("FAIL after_reset got lat=%0d pt=%h ovf=%b required lat=3 pt=%h ovf=0",
                      lat, bus_a.out_point, bus_a.out_ovf, pt(ONE, 2*ONE, 3*ONE));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    id_m = mat(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE);
    rz_m = mat(0, 32'hFFFF0000, 0, ONE, 0, 0, 0, 0, ONE);
    bus_a.in_valid  = 1'b0;
    bus_a.in_mode   = 2'b00;
    bus_a.in_point  = '0;
    bus_a.in_rot    = '0;
    bus_a.in_scale  = '0;
    bus_a.in_trans  = '0;
    bus_a.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_mode_srt();
    test_modes_r_rt_pass();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
